// File: rtl/e203_defines.sv
// ============================================================================
// Module : e203_defines
// Brief  : Shared core-wide widths and depths used by the EXU long-pipe logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package e203_defines;

  localparam int E203_OITF_DEPTH  = 2;
  localparam int E203_ITAG_WIDTH  = 1;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE     = 32;

endpackage

`default_nettype wire

// File: rtl/e203_exu_oitf_entry.sv
// ============================================================================
// Module : e203_exu_oitf_entry
// Brief  : One OITF slot: valid bit, rd payload and PC, plus hazard compare
//          against the three source operands and the destination of the
//          instruction currently at dispatch (index 0..2 = rs1..rs3, 3 = rd).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module e203_exu_oitf_entry
  import e203_defines::*;
#(
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int PC_W    = E203_PC_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set,
  input  logic                    clr,
  input  logic                    set_rdwen,
  input  logic [RFIDX_W-1:0]      set_rdidx,
  input  logic                    set_rdfpu,
  input  logic [PC_W-1:0]         set_pc,
  output logic                    rdwen,
  output logic [RFIDX_W-1:0]      rdidx,
  output logic                    rdfpu,
  output logic [PC_W-1:0]         pc,
  input  logic [3:0]              cmp_en,
  input  logic [3:0][RFIDX_W-1:0] cmp_idx,
  input  logic [3:0]              cmp_fpu,
  output logic [3:0]              match
);

  localparam int c_pay_w = 1 + RFIDX_W + 1 + PC_W;

  logic               r_vld;
  logic               w_vld_lden;
  logic               w_vld_nxt;
  logic [c_pay_w-1:0] w_pay_nxt;
  logic [c_pay_w-1:0] r_pay;

  // Set and clear never target the same slot in one cycle (only possible
  // when the FIFO is empty or full, where one of them is blocked).
  assign w_vld_lden = set | clr;
  assign w_vld_nxt  = set;

  sirv_gnrl_dfflr #(.DW(1)) u_vld (
    .lden  (w_vld_lden),
    .dnxt  (w_vld_nxt),
    .qout  (r_vld),
    .clk   (clk),
    .rst_n (rst_n)
  );

  assign w_pay_nxt = {set_rdwen, set_rdidx, set_rdfpu, set_pc};

  // Payload is left stale on retire; only the valid bit gates matching.
  sirv_gnrl_dfflr #(.DW(c_pay_w)) u_pay (
    .lden  (set),
    .dnxt  (w_pay_nxt),
    .qout  (r_pay),
    .clk   (clk),
    .rst_n (rst_n)
  );

  assign {rdwen, rdidx, rdfpu, pc} = r_pay;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_cmp
      assign match[k] = cmp_en[k] & r_vld & rdwen
                      & (rdidx == cmp_idx[k]) & (rdfpu == cmp_fpu[k]);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sirv_gnrl_dfflr.sv
// ============================================================================
// Module : sirv_gnrl_dfflr
// Brief  : General D flip-flop with load enable and async active-low reset to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  logic [DW-1:0] r_q;

  // Hold unless loaded; reset clears to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (lden) r_q <= dnxt;
  end

  assign qout = r_q;

endmodule

`default_nettype wire

// File: rtl/e203_exu_longp_oitf.sv
// ============================================================================
// Module : e203_exu_longp_oitf
// Brief  : Outstanding Instruction Track FIFO for long-pipe instructions.
//          Allocates an itag per dispatch, presents the oldest entry for
//          write-back retirement, and reports RAW/WAW hazards to dispatch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module e203_exu_longp_oitf
  import e203_defines::*;
#(
  parameter int OITF_DEPTH = E203_OITF_DEPTH,
  parameter int PTR_W      = E203_ITAG_WIDTH,
  parameter int RFIDX_W    = E203_RFIDX_WIDTH,
  parameter int PC_W       = E203_PC_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dis_ena,
  output logic               dis_ready,
  output logic [PTR_W-1:0]   dis_ptr,
  input  logic               disp_i_rdwen,
  input  logic [RFIDX_W-1:0] disp_i_rdidx,
  input  logic               disp_i_rdfpu,
  input  logic [PC_W-1:0]    disp_i_pc,
  input  logic               disp_i_rs1en,
  input  logic               disp_i_rs2en,
  input  logic               disp_i_rs3en,
  input  logic [RFIDX_W-1:0] disp_i_rs1idx,
  input  logic [RFIDX_W-1:0] disp_i_rs2idx,
  input  logic [RFIDX_W-1:0] disp_i_rs3idx,
  input  logic               disp_i_rs1fpu,
  input  logic               disp_i_rs2fpu,
  input  logic               disp_i_rs3fpu,
  output logic               oitfrd_match_disprs1,
  output logic               oitfrd_match_disprs2,
  output logic               oitfrd_match_disprs3,
  output logic               oitfrd_match_disprd,
  input  logic               ret_ena,
  output logic [PTR_W-1:0]   ret_ptr,
  output logic [RFIDX_W-1:0] ret_rdidx,
  output logic [PC_W-1:0]    ret_pc,
  output logic               ret_rdwen,
  output logic               ret_rdfpu,
  output logic               oitf_empty
);

  localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(OITF_DEPTH - 1);

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic             r_wr_flg, r_rd_flg;
  logic [PTR_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic             w_wr_flg_nxt, w_rd_flg_nxt;
  logic             w_full, w_empty, w_dis_fire, w_ret_fire;

  // Full/empty come from registered pointers only, so a same-cycle retire
  // never opens a slot for a same-cycle dispatch.
  assign w_empty    = (r_wr_ptr == r_rd_ptr) & (r_wr_flg == r_rd_flg);
  assign w_full     = (r_wr_ptr == r_rd_ptr) & (r_wr_flg != r_rd_flg);
  assign w_dis_fire = dis_ena & ~w_full;
  assign w_ret_fire = ret_ena & ~w_empty;

  assign w_wr_ptr_nxt = (r_wr_ptr == c_last_idx) ? '0 : r_wr_ptr + 1'b1;
  assign w_wr_flg_nxt = r_wr_flg ^ (r_wr_ptr == c_last_idx);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_last_idx) ? '0 : r_rd_ptr + 1'b1;
  assign w_rd_flg_nxt = r_rd_flg ^ (r_rd_ptr == c_last_idx);

  sirv_gnrl_dfflr #(.DW(PTR_W + 1)) u_wr_ptr (
    .lden  (w_dis_fire),
    .dnxt  ({w_wr_flg_nxt, w_wr_ptr_nxt}),
    .qout  ({r_wr_flg, r_wr_ptr}),
    .clk   (clk),
    .rst_n (rst_n)
  );

  sirv_gnrl_dfflr #(.DW(PTR_W + 1)) u_rd_ptr (
    .lden  (w_ret_fire),
    .dnxt  ({w_rd_flg_nxt, w_rd_ptr_nxt}),
    .qout  ({r_rd_flg, r_rd_ptr}),
    .clk   (clk),
    .rst_n (rst_n)
  );

  // Operand slot order shared with every entry: rs1, rs2, rs3, rd
  logic [3:0]              w_cmp_en;
  logic [3:0][RFIDX_W-1:0] w_cmp_idx;
  logic [3:0]              w_cmp_fpu;

  assign w_cmp_en  = {disp_i_rdwen,  disp_i_rs3en,  disp_i_rs2en,  disp_i_rs1en};
  assign w_cmp_idx = {disp_i_rdidx,  disp_i_rs3idx, disp_i_rs2idx, disp_i_rs1idx};
  assign w_cmp_fpu = {disp_i_rdfpu,  disp_i_rs3fpu, disp_i_rs2fpu, disp_i_rs1fpu};

  logic               w_ent_rdwen [OITF_DEPTH];
  logic [RFIDX_W-1:0] w_ent_rdidx [OITF_DEPTH];
  logic               w_ent_rdfpu [OITF_DEPTH];
  logic [PC_W-1:0]    w_ent_pc    [OITF_DEPTH];
  logic [3:0]         w_ent_match [OITF_DEPTH];

  genvar i;
  generate
    for (i = 0; i < OITF_DEPTH; i++) begin : g_entry
      e203_exu_oitf_entry #(
        .RFIDX_W (RFIDX_W),
        .PC_W    (PC_W)
      ) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (w_dis_fire & (r_wr_ptr == PTR_W'(i))),
        .clr       (w_ret_fire & (r_rd_ptr == PTR_W'(i))),
        .set_rdwen (disp_i_rdwen),
        .set_rdidx (disp_i_rdidx),
        .set_rdfpu (disp_i_rdfpu),
        .set_pc    (disp_i_pc),
        .rdwen     (w_ent_rdwen[i]),
        .rdidx     (w_ent_rdidx[i]),
        .rdfpu     (w_ent_rdfpu[i]),
        .pc        (w_ent_pc[i]),
        .cmp_en    (w_cmp_en),
        .cmp_idx   (w_cmp_idx),
        .cmp_fpu   (w_cmp_fpu),
        .match     (w_ent_match[i])
      );
    end
  endgenerate

  logic [3:0] w_match_any;

  // OR the per-entry hazard hits across all slots
  always_comb begin
    w_match_any = '0;
    for (int j = 0; j < OITF_DEPTH; j++) begin
      w_match_any = w_match_any | w_ent_match[j];
    end
  end

  assign oitfrd_match_disprs1 = w_match_any[0];
  assign oitfrd_match_disprs2 = w_match_any[1];
  assign oitfrd_match_disprs3 = w_match_any[2];
  assign oitfrd_match_disprd  = w_match_any[3];

  assign dis_ready  = ~w_full;
  assign dis_ptr    = r_wr_ptr;
  assign ret_ptr    = r_rd_ptr;
  assign oitf_empty = w_empty;

  // Oldest entry is read straight out of its slot; itag equals slot index
  assign ret_rdwen = w_ent_rdwen[r_rd_ptr];
  assign ret_rdidx = w_ent_rdidx[r_rd_ptr];
  assign ret_rdfpu = w_ent_rdfpu[r_rd_ptr];
  assign ret_pc    = w_ent_pc[r_rd_ptr];

`ifdef E203_OITF_PROTOCOL_CHECKS
`ifndef SYNTHESIS
  // Upstream handshakes are expected to respect oitf_empty and dis_ready;
  // the FIFO ignores violations, these checks make them visible.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(ret_ena && w_empty)) else $error("oitf: retire while empty");
      assert (!(dis_ena && w_full))  else $error("oitf: dispatch while full");
    end
  end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_e203_exu_longp_oitf.sv
// ============================================================================
// Module : tb_e203_exu_longp_oitf
// Brief  : Self-checking bench for the long-pipe OITF. A queue-based model of
//          outstanding instructions predicts every output each cycle; directed
//          scenarios pin the model with hand-computed values, then randomized
//          traffic (with occasional async resets) exercises the rest.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_e203_exu_longp_oitf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dis_ena = 1'b0;
  logic        dis_ready;
  logic [0:0]  dis_ptr;
  logic        disp_i_rdwen = 1'b0;
  logic [4:0]  disp_i_rdidx = '0;
  logic        disp_i_rdfpu = 1'b0;
  logic [31:0] disp_i_pc = '0;
  logic        disp_i_rs1en = 1'b0, disp_i_rs2en = 1'b0, disp_i_rs3en = 1'b0;
  logic [4:0]  disp_i_rs1idx = '0, disp_i_rs2idx = '0, disp_i_rs3idx = '0;
  logic        disp_i_rs1fpu = 1'b0, disp_i_rs2fpu = 1'b0, disp_i_rs3fpu = 1'b0;
  logic        oitfrd_match_disprs1, oitfrd_match_disprs2;
  logic        oitfrd_match_disprs3, oitfrd_match_disprd;
  logic        ret_ena = 1'b0;
  logic [0:0]  ret_ptr;
  logic [4:0]  ret_rdidx;
  logic [31:0] ret_pc;
  logic        ret_rdwen, ret_rdfpu;
  logic        oitf_empty;

  e203_exu_longp_oitf dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .dis_ena              (dis_ena),
    .dis_ready            (dis_ready),
    .dis_ptr              (dis_ptr),
    .disp_i_rdwen         (disp_i_rdwen),
    .disp_i_rdidx         (disp_i_rdidx),
    .disp_i_rdfpu         (disp_i_rdfpu),
    .disp_i_pc            (disp_i_pc),
    .disp_i_rs1en         (disp_i_rs1en),
    .disp_i_rs2en         (disp_i_rs2en),
    .disp_i_rs3en         (disp_i_rs3en),
    .disp_i_rs1idx        (disp_i_rs1idx),
    .disp_i_rs2idx        (disp_i_rs2idx),
    .disp_i_rs3idx        (disp_i_rs3idx),
    .disp_i_rs1fpu        (disp_i_rs1fpu),
    .disp_i_rs2fpu        (disp_i_rs2fpu),
    .disp_i_rs3fpu        (disp_i_rs3fpu),
    .oitfrd_match_disprs1 (oitfrd_match_disprs1),
    .oitfrd_match_disprs2 (oitfrd_match_disprs2),
    .oitfrd_match_disprs3 (oitfrd_match_disprs3),
    .oitfrd_match_disprd  (oitfrd_match_disprd),
    .ret_ena              (ret_ena),
    .ret_ptr              (ret_ptr),
    .ret_rdidx            (ret_rdidx),
    .ret_pc               (ret_pc),
    .ret_rdwen            (ret_rdwen),
    .ret_rdfpu            (ret_rdfpu),
    .oitf_empty           (oitf_empty)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        rdwen;
    logic [4:0]  rdidx;
    logic        rdfpu;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];          // outstanding instructions, oldest first
  int   alloc_cnt = 0; // allocations since reset -> itag = alloc_cnt mod DEPTH
  int   ret_cnt   = 0; // retirements since reset
  int   n_vec = 0;
  int   n_err = 0;
  bit   cmp_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_match(input logic en, input logic [4:0] idx, input logic fpu);
    exp_match = 1'b0;
    if (en)
      foreach (q[n])
        if (q[n].rdwen && q[n].rdidx == idx && q[n].rdfpu == fpu) exp_match = 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    alloc_cnt = 0;
    ret_cnt   = 0;
  endtask

  // Evaluated at the active edge with the inputs the DUT sampled
  task automatic model_step();
    bit   full, empty;
    ent_t e;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (ret_ena && !empty) begin
      void'(q.pop_front());
      ret_cnt++;
    end
    if (dis_ena && !full) begin
      e.rdwen = disp_i_rdwen; e.rdidx = disp_i_rdidx;
      e.rdfpu = disp_i_rdfpu; e.pc    = disp_i_pc;
      q.push_back(e);
      alloc_cnt++;
    end
  endtask

  // Per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmp_on) begin
      chk("oitf_empty", oitf_empty, q.size() == 0);
      chk("dis_ready",  dis_ready,  q.size() < DEPTH);
      chk("dis_ptr",    dis_ptr,    alloc_cnt % DEPTH);
      chk("ret_ptr",    ret_ptr,    ret_cnt % DEPTH);
      chk("match_rs1",  oitfrd_match_disprs1, exp_match(disp_i_rs1en, disp_i_rs1idx, disp_i_rs1fpu));
      chk("match_rs2",  oitfrd_match_disprs2, exp_match(disp_i_rs2en, disp_i_rs2idx, disp_i_rs2fpu));
      chk("match_rs3",  oitfrd_match_disprs3, exp_match(disp_i_rs3en, disp_i_rs3idx, disp_i_rs3fpu));
      chk("match_rd",   oitfrd_match_disprd,  exp_match(disp_i_rdwen, disp_i_rdidx, disp_i_rdfpu));
      if (q.size() > 0) begin
        chk("ret_rdwen", ret_rdwen, q[0].rdwen);
        chk("ret_rdidx", ret_rdidx, q[0].rdidx);
        chk("ret_rdfpu", ret_rdfpu, q[0].rdfpu);
        chk("ret_pc",    ret_pc,    q[0].pc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cycle(input logic d, input logic r);
    dis_ena = d;
    ret_ena = r;
    @(posedge clk);
    model_step();
    #1;
    dis_ena = 1'b0;
    ret_ena = 1'b0;
  endtask

  task automatic set_disp(input logic we, input logic [4:0] idx, input logic fpu, input logic [31:0] pc);
    disp_i_rdwen = we; disp_i_rdidx = idx; disp_i_rdfpu = fpu; disp_i_pc = pc;
  endtask

  task automatic set_srcs(input logic e1, input logic [4:0] i1, input logic f1,
                          input logic e2, input logic [4:0] i2, input logic f2,
                          input logic e3, input logic [4:0] i3, input logic f3);
    disp_i_rs1en = e1; disp_i_rs1idx = i1; disp_i_rs1fpu = f1;
    disp_i_rs2en = e2; disp_i_rs2idx = i2; disp_i_rs2fpu = f2;
    disp_i_rs3en = e3; disp_i_rs3idx = i3; disp_i_rs3fpu = f3;
  endtask

  // Assert rst_n away from the clock edge and check the async clear
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_empty",   oitf_empty, 1'b1);
    chk("async_rst_ready",   dis_ready,  1'b1);
    chk("async_rst_dis_ptr", dis_ptr,    1'b0);
    chk("async_rst_ret_ptr", ret_ptr,    1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // 1: reset state (sources enabled on x0 so a spurious match would show)
    set_srcs(1, 5'd0, 0, 1, 5'd0, 0, 1, 5'd0, 0);
    set_disp(1, 5'd0, 0, 32'h0);
    #1;
    chk("t1_empty",   oitf_empty, 1'b1);
    chk("t1_ready",   dis_ready,  1'b1);
    chk("t1_dis_ptr", dis_ptr,    1'b0);
    chk("t1_ret_ptr", ret_ptr,    1'b0);
    chk("t1_ret_pc",  ret_pc,     32'h0);
    chk("t1_ret_idx", ret_rdidx,  5'd0);
    chk("t1_matches", {oitfrd_match_disprs1, oitfrd_match_disprs2,
                       oitfrd_match_disprs3, oitfrd_match_disprd}, 4'b0000);
    set_srcs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_on = 1'b1;

    // 2: fill with x5 / x6
    set_disp(1, 5'd5, 0, 32'h8000_0010);
    chk("t2_itag0", dis_ptr, 1'b0);
    do_cycle(1, 0);
    set_disp(1, 5'd6, 0, 32'h8000_0014);
    chk("t2_itag1", dis_ptr, 1'b1);
    do_cycle(1, 0);
    chk("t2_ready_full", dis_ready, 1'b0);
    chk("t2_ret_ptr",    ret_ptr,   1'b0);
    chk("t2_ret_idx",    ret_rdidx, 5'd5);
    chk("t2_ret_pc",     ret_pc,    32'h8000_0010);

    // 3: dispatch + retire while full -> only the retire happens
    set_disp(1, 5'd9, 0, 32'h8000_0018);
    do_cycle(1, 1);
    chk("t3_ret_ptr", ret_ptr,   1'b1);
    chk("t3_ready",   dis_ready, 1'b1);
    chk("t3_ret_idx", ret_rdidx, 5'd6);
    chk("t3_ret_pc",  ret_pc,    32'h8000_0014);
    chk("t3_dis_ptr", dis_ptr,   1'b0);

    // 4: drain then wrap: itags 0,1,0
    do_cycle(0, 1);
    chk("t4_empty", oitf_empty, 1'b1);
    chk("t4_itag_a", dis_ptr, 1'b0);
    set_disp(1, 5'd10, 0, 32'h8000_0020);
    do_cycle(1, 0);
    chk("t4_itag_b", dis_ptr, 1'b1);
    set_disp(1, 5'd11, 1, 32'h8000_0024);
    do_cycle(1, 0);
    chk("t4_full", dis_ready, 1'b0);
    do_cycle(0, 1);
    chk("t4_not_full", dis_ready, 1'b1);
    chk("t4_itag_c", dis_ptr, 1'b0);
    set_disp(1, 5'd12, 0, 32'h8000_0028);
    do_cycle(1, 0);
    chk("t4_full2",  dis_ready,  1'b0);
    chk("t4_nempty", oitf_empty, 1'b0);

    // 5: hazards against a valid x7 int entry
    do_cycle(0, 1);
    do_cycle(0, 1);
    set_disp(1, 5'd7, 0, 32'h8000_0030);
    do_cycle(1, 0);
    set_srcs(1, 5'd7, 0, 1, 5'd7, 1, 0, 5'd7, 0);
    set_disp(1, 5'd7, 0, 32'h8000_0034);
    #1;
    chk("t5_rs1", oitfrd_match_disprs1, 1'b1);
    chk("t5_rs2", oitfrd_match_disprs2, 1'b0);
    chk("t5_rs3", oitfrd_match_disprs3, 1'b0);
    chk("t5_rd",  oitfrd_match_disprd,  1'b1);
    do_cycle(0, 1);
    set_disp(0, 5'd7, 0, 32'h8000_0038);
    do_cycle(1, 0);
    set_disp(1, 5'd7, 0, 32'h8000_003c);
    #1;
    chk("t5_nowen", {oitfrd_match_disprs1, oitfrd_match_disprs2,
                     oitfrd_match_disprs3, oitfrd_match_disprd}, 4'b0000);

    // 6: dispatch + retire at occupancy 1, then async reset mid-stream
    chk("t6_ret_ptr_pre", ret_ptr, 1'b0);
    do_cycle(1, 1);
    chk("t6_ret_ptr", ret_ptr,    1'b1);
    chk("t6_nempty",  oitf_empty, 1'b0);
    chk("t6_ready",   dis_ready,  1'b1);
    chk("t6_ret_pc",  ret_pc,     32'h8000_003c);
    async_reset();

    // Randomized traffic; small register range to provoke hazards
    for (int c = 0; c < 800; c++) begin
      logic d, r;
      set_disp(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom);
      set_srcs(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ((c / 100) % 2 == 0) begin
        d = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 1) != 0);
      end else begin
        d = ($urandom_range(0, 1) != 0);
        r = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 99) == 0) async_reset();
      else do_cycle(d, r);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
